// File: rtl/inst_fetch.sv
// Instruction fetch front end: issues single outstanding word reads at the fetch PC,
// buffers {pc, inst} pairs in a small FIFO for decode, and handles redirects.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] PC_INCR    = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_inst,
  output logic [31:0] fetch_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [31:0]        r_fpc;
  logic [31:0]        w_next_fpc;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [31:0]        r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]        r_fifo_inst [FIFO_DEPTH];

  logic w_outstanding;
  logic w_room;
  logic w_push;
  logic w_pop;

  // Room counts the in-flight read so its response always has a slot.
  assign w_outstanding = (r_state != S_IDLE);
  assign w_room        = (int'(r_count) + int'(w_outstanding)) < FIFO_DEPTH;

  assign imem_req  = (r_state == S_IDLE) & w_room & ~redirect & ~reset;
  assign imem_addr = r_fpc;

  assign w_push = (r_state == S_WAIT) & imem_rvalid & ~redirect;
  assign w_pop  = fetch_valid & ~stall & ~redirect;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_next_fpc   = r_fpc;
    case (r_state)
      S_IDLE: begin
        if (redirect) begin
          w_next_fpc = redirect_pc;
        end else if (imem_req) begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          w_next_fpc   = redirect_pc;
          w_next_state = imem_rvalid ? S_IDLE : S_DRAIN;
        end else if (imem_rvalid) begin
          w_next_fpc   = r_fpc + PC_INCR;
          w_next_state = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          w_next_fpc = redirect_pc;
        end
        if (imem_rvalid) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_fpc   <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      r_fpc   <= w_next_fpc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (redirect) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; the count gates visibility so stale contents never escape.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_fpc;
      r_fifo_inst[r_wr_ptr] <= imem_rdata;
    end
  end

  assign fetch_valid = (r_count != '0);
  assign fetch_inst  = fetch_valid ? r_fifo_inst[r_rd_ptr] : 32'h0;
  assign fetch_pc    = fetch_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a delay-k memory model answers each request with addr+1.
module tb_inst_fetch;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;

  inst_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .fetch_valid (fetch_valid),
    .fetch_inst  (fetch_inst),
    .fetch_pc    (fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // memory model state
  bit          mem_en;
  int          mem_k;
  int          pend_cnt;
  logic [31:0] pend_addr;

  // outputs sampled on the falling edge of the last cycle
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_fv;
  logic [31:0] s_inst;
  logic [31:0] s_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample outputs mid-cycle, then advance the memory model after the edge.
  task automatic tick();
    @(negedge clk);
    s_req  = imem_req;
    s_addr = imem_addr;
    s_fv   = fetch_valid;
    s_inst = fetch_inst;
    s_pc   = fetch_pc;
    if (mem_en && imem_req) begin
      pend_addr = imem_addr;
      pend_cnt  = mem_k;
    end
    @(posedge clk);
    #1;
    if (mem_en) begin
      imem_rvalid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = pend_addr + 32'd1;
        end
      end
    end
  endtask

  task automatic do_reset(input int k);
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    pend_cnt    = 0;
    mem_en      = 1'b1;
    mem_k       = k;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    check({tag, "_fv"}, {31'h0, s_fv}, 32'h1);
    check({tag, "_pc"}, s_pc, pc);
    check({tag, "_inst"}, s_inst, inst);
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    mem_en      = 1'b1;
    mem_k       = 1;
    pend_cnt    = 0;
    pend_addr   = 32'h0;

    // Reset state
    tick();
    check("rst_req",  {31'h0, s_req}, 32'h0);
    check("rst_fv",   {31'h0, s_fv},  32'h0);
    check("rst_inst", s_inst, 32'h0);
    check("rst_pc",   s_pc,   32'h0);

    // 1: sequential fetch, k=1
    do_reset(1);
    tick();                                    // C0
    check("t1_req0", {31'h0, s_req}, 32'h1);
    check("t1_addr0", s_addr, 32'h0);
    check("t1_fv0", {31'h0, s_fv}, 32'h0);
    tick();                                    // C1
    check("t1_req1", {31'h0, s_req}, 32'h0);
    tick();                                    // C2
    check("t1_addr4", s_addr, 32'h4);
    expect_fetch("t1_f0", 32'h0, 32'h1);
    tick();                                    // C3
    check("t1_fv3", {31'h0, s_fv}, 32'h0);
    tick();                                    // C4
    check("t1_addr8", s_addr, 32'h8);
    expect_fetch("t1_f4", 32'h4, 32'h5);
    tick();                                    // C5
    tick();                                    // C6
    expect_fetch("t1_f8", 32'h8, 32'h9);

    // 2: stall for 10 cycles fills the FIFO, then drains in order
    do_reset(1);
    stall = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();                                  // C0..C9
      if (c >= 4) check($sformatf("t2_noreq%0d", c), {31'h0, s_req}, 32'h0);
    end
    expect_fetch("t2_hold", 32'h0, 32'h1);
    stall = 1'b0;
    tick();                                    // C10
    expect_fetch("t2_d0", 32'h0, 32'h1);
    check("t2_req10", {31'h0, s_req}, 32'h0);
    tick();                                    // C11
    expect_fetch("t2_d1", 32'h4, 32'h5);
    check("t2_req11", {31'h0, s_req}, 32'h1);
    check("t2_addr11", s_addr, 32'h8);
    tick();                                    // C12
    check("t2_fv12", {31'h0, s_fv}, 32'h0);
    tick();                                    // C13
    expect_fetch("t2_resume", 32'h8, 32'h9);

    // 3: redirect in WAIT, stale response two cycles later
    do_reset(3);
    tick();                                    // C0 req 0
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();                                    // C1 -> DRAIN
    redirect = 1'b0;
    tick();                                    // C2
    check("t3_req2", {31'h0, s_req}, 32'h0);
    tick();                                    // C3 stale rvalid dropped
    check("t3_req3", {31'h0, s_req}, 32'h0);
    tick();                                    // C4
    check("t3_req4", {31'h0, s_req}, 32'h1);
    check("t3_addr4", s_addr, 32'h100);
    check("t3_fv4", {31'h0, s_fv}, 32'h0);
    for (int c = 5; c < 8; c++) begin
      tick();
      check($sformatf("t3_fv%0d", c), {31'h0, s_fv}, 32'h0);
    end
    tick();                                    // C8
    expect_fetch("t3_f", 32'h100, 32'h101);

    // 4: redirect coincident with rvalid, FIFO holding an entry
    do_reset(1);
    stall = 1'b1;
    tick();                                    // C0
    tick();                                    // C1 push
    tick();                                    // C2 req 4
    check("t4_addr2", s_addr, 32'h4);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();                                    // C3 rvalid + redirect
    check("t4_fv3", {31'h0, s_fv}, 32'h1);
    redirect = 1'b0; stall = 1'b0;
    tick();                                    // C4
    check("t4_fv4", {31'h0, s_fv}, 32'h0);
    check("t4_req4", {31'h0, s_req}, 32'h1);
    check("t4_addr4", s_addr, 32'h200);
    tick();                                    // C5
    tick();                                    // C6
    expect_fetch("t4_f", 32'h200, 32'h201);

    // 5: redirects while draining; only the last target is fetched
    do_reset(4);
    tick();                                    // C0
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();                                    // C1
    redirect_pc = 32'h300;
    tick();                                    // C2
    redirect_pc = 32'h400;
    tick();                                    // C3
    check("t5_req3", {31'h0, s_req}, 32'h0);
    redirect = 1'b0;
    tick();                                    // C4 stale rvalid
    check("t5_req4", {31'h0, s_req}, 32'h0);
    tick();                                    // C5
    check("t5_req5", {31'h0, s_req}, 32'h1);
    check("t5_addr5", s_addr, 32'h400);
    for (int c = 6; c < 10; c++) begin
      tick();
      check($sformatf("t5_fv%0d", c), {31'h0, s_fv}, 32'h0);
    end
    tick();                                    // C10
    expect_fetch("t5_f", 32'h400, 32'h401);

    // 6: reset in WAIT with one buffered entry; later rvalid is ignored
    do_reset(3);
    stall = 1'b1;
    for (int c = 0; c < 5; c++) tick();        // C0..C4, req 4 issued in C4
    check("t6_fv4", {31'h0, s_fv}, 32'h1);
    reset = 1'b1; mem_en = 1'b0; pend_cnt = 0; imem_rvalid = 1'b0;
    tick();                                    // C5 in reset
    check("t6_req_rst", {31'h0, s_req}, 32'h0);
    check("t6_fv_rst", {31'h0, s_fv}, 32'h0);
    check("t6_inst_rst", s_inst, 32'h0);
    check("t6_pc_rst", s_pc, 32'h0);
    reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD;
    tick();                                    // C6 stale rvalid in IDLE
    check("t6_req6", {31'h0, s_req}, 32'h1);
    check("t6_addr6", s_addr, 32'h0);
    imem_rvalid = 1'b0;
    tick();                                    // C7
    check("t6_fv7", {31'h0, s_fv}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h55;
    tick();                                    // C8 real response
    imem_rvalid = 1'b0;
    tick();                                    // C9
    expect_fetch("t6_f", 32'h0, 32'h55);

    // 7: redirect in IDLE to the top word, PC wraps to 0
    do_reset(1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();                                    // C0
    check("t7_req0", {31'h0, s_req}, 32'h0);
    redirect = 1'b0;
    tick();                                    // C1
    check("t7_addr1", s_addr, 32'hFFFF_FFFC);
    tick();                                    // C2
    tick();                                    // C3
    expect_fetch("t7_f", 32'hFFFF_FFFC, 32'hFFFF_FFFD);
    check("t7_wrap", s_addr, 32'h0);
    check("t7_wrap_req", {31'h0, s_req}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
